imem_boot_loader: RTL

//  Writer side of the instruction-memory interface. Receives a byte stream (valid/ready) carrying a

---
 rtl/imem_boot_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream program loader that writes big-endian words to instruction memory and holds the cpu in reset until the image checksum verifies
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR} state_t;
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [ADDR_WIDTH:0] idx_q, idx_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic [7:0] chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0] err_q, err_d;
  logic xfer;
  assign rx_ready = state_q inside {LEN_HI, LEN_LO, DATA, CHECK};
  assign xfer = rx_valid & rx_ready;
  assign mem_write_en = state_q == WRITE;
  assign mem_write_addr = addr_q;
  assign mem_write_data = data_q;
  assign busy = state_q inside {LEN_HI, LEN_LO, DATA, WRITE, CHECK};
  assign done = state_q == DONE;
  assign cpu_rst = state_q != DONE;
  assign error = err_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
    chk_d = chk_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LEN_HI;
        idx_d = '0;
        bcnt_d = '0;
        chk_d = '0;
        err_d = '0;
      end
      LEN_HI: if (xfer) begin
        len_d[15:8] = rx_data;
        state_d = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        len_d[7:0] = rx_data;
        state_d = {1'b0, len_q[15:8], rx_data} > MAX_N ? ERR :
                  {len_q[15:8], rx_data} == 16'd0 ? CHECK : DATA;
        err_d = {1'b0, len_q[15:8], rx_data} > MAX_N ? 2'd1 : 2'd0;
      end
      DATA: if (xfer) begin
        chk_d = chk_q ^ rx_data;
        bcnt_d = bcnt_q + 2'd1;
        word_d = {word_q[15:0], rx_data};
        // the 4th byte goes straight to the output register so WRITE presents it
        if (bcnt_q == 2'd3) begin
          data_d = {word_q, rx_data};
          addr_d = idx_q[ADDR_WIDTH-1:0];
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + (ADDR_WIDTH+1)'(1);
        state_d = 16'(idx_q) + 16'd1 == len_q ? CHECK : DATA;
      end
      CHECK: if (xfer) begin
        state_d = rx_data == chk_q ? DONE : ERR;
        err_d = rx_data == chk_q ? 2'd0 : 2'd2;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      chk_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      chk_q <= chk_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
endmodule
